fifo_wr_arbiter: RTL and testbench

- Write-domain controller for the async FIFO.
- Shares the single FIFO write port among NUM_REQ requesters by round-robin arbitration, with optional packet locking.
- Owns the write pointer (binary and gray).
- Derives full and fill level from the read pointer, which reaches this block already synchronized into the write domain as a gray value.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO write/read controllers.
package fifo_pkg;

    // Widest pointer the gray helpers handle; callers zero-extend narrower pointers.
    localparam int unsigned PTR_MAX_W   = 16;
    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned GRANT_W_DEF = $clog2(NUM_REQ_DEF);

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // Both conversions are width-independent as long as unused upper bits are zero.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down, done in log2 steps.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = g;
        for (int unsigned s = 1; s < PTR_MAX_W; s = s << 1) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first valid requester at or above rr_ptr_i, wrapping.
module rr_arbiter
    import fifo_pkg::*;
#(
    parameter int unsigned N  = NUM_REQ_DEF,
    parameter int unsigned GW = GRANT_W_DEF
) (
    input  logic [N-1:0]  valid_i,
    input  logic [GW-1:0] rr_ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [GW-1:0] grant_idx_o,
    output logic          any_o
);

    int unsigned   idx;
    logic [GW-1:0] idx_w;

    // Scan N positions starting at rr_ptr_i; the first valid one wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        idx         = 0;
        idx_w       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx   = (32'(rr_ptr_i) + k) % N;
            idx_w = GW'(idx);
            if (!any_o && valid_i[idx_w]) begin
                any_o          = 1'b1;
                grant_o[idx_w] = 1'b1;
                grant_idx_o    = idx_w;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-domain controller of the async FIFO: round-robin write-port sharing with
// packet locking, write pointer ownership, full flag and fill level.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int unsigned address_Size = 3,
    parameter int unsigned data_Width   = 8,
    parameter int unsigned NUM_REQ      = NUM_REQ_DEF
) (
    input  logic                            w_Clk,
    input  logic                            w_Rst,
    input  logic [NUM_REQ-1:0]              req_Valid,
    input  logic [NUM_REQ-1:0]              req_Last,
    input  logic [NUM_REQ*data_Width-1:0]   req_Data,
    output logic [NUM_REQ-1:0]              req_Ready,
    input  logic [address_Size:0]           wsync_Rptr,
    output logic                            w_En,
    output logic [address_Size-1:0]         w_Addr,
    output logic [data_Width-1:0]           w_Data,
    output logic [address_Size:0]           w_Ptr,
    output logic                            w_Full,
    output logic [address_Size:0]           w_Level,
    output logic [$clog2(NUM_REQ)-1:0]      grant_Id
);

    localparam int unsigned PW = address_Size + 1;
    localparam int unsigned GW = $clog2(NUM_REQ);
    // Inverting the top two gray bits gives "one lap ahead"; works down to PW=2.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    arb_state_t       state_q;
    logic [GW-1:0]    owner_q;
    logic [GW-1:0]    rr_q;
    logic [PW-1:0]    bin_q;
    logic [PW-1:0]    gray_q;
    logic             full_q;
    logic [PW-1:0]    level_q;

    logic [NUM_REQ-1:0] arb_onehot;
    logic [GW-1:0]      arb_idx;
    logic               arb_any;

    logic [NUM_REQ-1:0] grant_vec;
    logic [GW-1:0]      grantee;
    logic [GW-1:0]      rr_next;
    logic               last_beat;
    logic [PW-1:0]      bin_d;
    logic [PW-1:0]      gray_d;
    logic               full_d;
    logic [PW-1:0]      level_d;
    logic [PW-1:0]      rptr_bin;

    rr_arbiter #(
        .N  (NUM_REQ),
        .GW (GW)
    ) u_rr (
        .valid_i     (req_Valid),
        .rr_ptr_i    (rr_q),
        .grant_o     (arb_onehot),
        .grant_idx_o (arb_idx),
        .any_o       (arb_any)
    );

    // Grant selection, handshake, memory write port and next pointer/flag values.
    always_comb begin
        grant_vec = '0;
        if (state_q == HOLD) begin
            grantee            = owner_q;
            grant_vec[owner_q] = 1'b1;
        end else begin
            grantee   = arb_idx;
            grant_vec = arb_onehot;
        end

        req_Ready = (full_q || w_Rst) ? '0 : grant_vec;
        w_En      = |(req_Valid & req_Ready);
        w_Data    = req_Data[grantee*data_Width +: data_Width];
        w_Addr    = bin_q[address_Size-1:0];
        grant_Id  = w_Rst ? '0 : grantee;
        last_beat = req_Last[grantee];
        rr_next   = (grantee == GW'(NUM_REQ - 1)) ? '0 : grantee + 1'b1;

        bin_d    = bin_q + PW'(w_En);
        gray_d   = PW'(bin2gray(PTR_MAX_W'(bin_d)));
        rptr_bin = PW'(gray2bin(PTR_MAX_W'(wsync_Rptr)));
        full_d   = (gray_d == (wsync_Rptr ^ FULL_MASK));
        level_d  = bin_d - rptr_bin;
    end

    // Write pointer, full flag and fill level registers.
    always_ff @(posedge w_Clk) begin
        if (w_Rst) begin
            bin_q   <= '0;
            gray_q  <= '0;
            full_q  <= 1'b0;
            level_q <= '0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            full_q  <= full_d;
            level_q <= level_d;
        end
    end

    // Arbitration FSM: ARB picks round-robin, HOLD keeps the port until the last beat.
    always_ff @(posedge w_Clk) begin
        if (w_Rst) begin
            state_q <= ARB;
            owner_q <= '0;
            rr_q    <= '0;
        end else if (w_En) begin
            case (state_q)
                ARB: begin
                    rr_q <= rr_next;
                    if (!last_beat) begin
                        state_q <= HOLD;
                        owner_q <= grantee;
                    end
                end
                HOLD: begin
                    if (last_beat) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign w_Ptr   = gray_q;
    assign w_Full  = full_q;
    assign w_Level = level_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (address_Size=3, data_Width=8, NUM_REQ=4).
module tb_fifo_wr_arbiter;

    localparam int AS    = 3;
    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int PW    = AS + 1;
    localparam int DEPTH = 1 << AS;
    localparam int PMOD  = 1 << PW;

    logic              w_Clk = 1'b0;
    logic              w_Rst;
    logic [NR-1:0]     req_Valid;
    logic [NR-1:0]     req_Last;
    logic [NR*DW-1:0]  req_Data;
    logic [NR-1:0]     req_Ready;
    logic [PW-1:0]     wsync_Rptr;
    logic              w_En;
    logic [AS-1:0]     w_Addr;
    logic [DW-1:0]     w_Data;
    logic [PW-1:0]     w_Ptr;
    logic              w_Full;
    logic [PW-1:0]     w_Level;
    logic [1:0]        grant_Id;

    fifo_wr_arbiter #(
        .address_Size (AS),
        .data_Width   (DW),
        .NUM_REQ      (NR)
    ) dut (
        .w_Clk      (w_Clk),
        .w_Rst      (w_Rst),
        .req_Valid  (req_Valid),
        .req_Last   (req_Last),
        .req_Data   (req_Data),
        .req_Ready  (req_Ready),
        .wsync_Rptr (wsync_Rptr),
        .w_En       (w_En),
        .w_Addr     (w_Addr),
        .w_Data     (w_Data),
        .w_Ptr      (w_Ptr),
        .w_Full     (w_Full),
        .w_Level    (w_Level),
        .grant_Id   (grant_Id)
    );

    always #5 w_Clk = ~w_Clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: plain counters, no gray arithmetic.
    int m_wr, m_full, m_level, m_rr, m_locked, m_owner;
    int m_g, m_acc;
    int rd_bin;
    int hist[$];

    // DUT outputs captured at the checking edge of the latest cycle.
    int cap_en, cap_gid, cap_full, cap_level, cap_ptr;

    typedef struct {
        bit       rst;
        bit [3:0] valid;
        bit [3:0] last;
        int       rd;
        bit       en;
        int       gid;
        bit       full;
        int       level;
        bit [3:0] ptr;
    } vec_t;

    vec_t vecs[14];
    int   got[$];
    int   exp_lock[5];

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_full = 0; m_level = 0; m_rr = 0; m_locked = 0; m_owner = 0;
    endtask

    function automatic int lagged_wr();
        return (hist.size() >= 3) ? hist[hist.size() - 3] : 0;
    endfunction

    // One clock cycle: drive rd pointer, check at negedge against the model, advance.
    task automatic do_cycle();
        int  g;
        bit  has;
        int  exp_ready;
        int  lvl;
        wsync_Rptr = PW'(gray(rd_bin));
        @(negedge w_Clk);
        has = 0;
        g   = 0;
        if (!w_Rst) begin
            if (m_locked != 0) begin
                has = 1;
                g   = m_owner;
            end else begin
                for (int k = 0; k < NR; k++) begin
                    if (!has && req_Valid[(m_rr + k) % NR]) begin
                        has = 1;
                        g   = (m_rr + k) % NR;
                    end
                end
            end
        end
        exp_ready = (has && m_full == 0) ? (1 << g) : 0;
        m_acc     = ((exp_ready & int'(req_Valid)) != 0) ? 1 : 0;
        m_g       = g;

        cap_en = int'(w_En); cap_gid = int'(grant_Id); cap_full = int'(w_Full);
        cap_level = int'(w_Level); cap_ptr = int'(w_Ptr);

        check("req_Ready", int'(req_Ready), exp_ready);
        check("w_En", cap_en, m_acc);
        check("w_Full", cap_full, m_full);
        check("w_Level", cap_level, m_level);
        check("w_Ptr", cap_ptr, gray(m_wr));
        if (m_acc != 0) begin
            check("grant_Id", cap_gid, g);
            check("w_Addr", int'(w_Addr), m_wr % DEPTH);
            check("w_Data", int'(w_Data), int'((req_Data >> (g * DW)) & 8'hFF));
        end

        if (w_Rst) begin
            model_reset();
        end else begin
            if (m_acc != 0) begin
                if (m_locked == 0) begin
                    m_rr = (g + 1) % NR;
                    if (!req_Last[g]) begin
                        m_locked = 1;
                        m_owner  = g;
                    end
                end else if (req_Last[g]) begin
                    m_locked = 0;
                end
                m_wr = (m_wr + 1) % PMOD;
            end
            lvl     = (m_wr - rd_bin + PMOD) % PMOD;
            m_level = lvl;
            m_full  = (lvl == DEPTH) ? 1 : 0;
        end
        hist.push_back(m_wr);
        @(posedge w_Clk);
        #1;
    endtask

    task automatic reset_dut(input int n);
        w_Rst = 1'b1; req_Valid = '0; req_Last = '0; rd_bin = 0;
        hist.delete();
        for (int i = 0; i < n; i++) do_cycle();
        w_Rst = 1'b0;
        hist.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vecs[0]  = '{1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'b0000};
        vecs[1]  = '{1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'b0000};
        vecs[2]  = '{0, 4'hF, 4'hF, 0, 1, 0, 0, 0, 4'b0000};
        vecs[3]  = '{0, 4'hF, 4'hF, 0, 1, 1, 0, 1, 4'b0001};
        vecs[4]  = '{0, 4'hF, 4'hF, 0, 1, 2, 0, 2, 4'b0011};
        vecs[5]  = '{0, 4'hF, 4'hF, 0, 1, 3, 0, 3, 4'b0010};
        vecs[6]  = '{0, 4'hF, 4'hF, 0, 1, 0, 0, 4, 4'b0110};
        vecs[7]  = '{0, 4'hF, 4'hF, 0, 1, 1, 0, 5, 4'b0111};
        vecs[8]  = '{0, 4'hF, 4'hF, 0, 1, 2, 0, 6, 4'b0101};
        vecs[9]  = '{0, 4'hF, 4'hF, 0, 1, 3, 0, 7, 4'b0100};
        vecs[10] = '{0, 4'hF, 4'hF, 0, 0, 0, 1, 8, 4'b1100};
        vecs[11] = '{0, 4'hF, 4'hF, 1, 0, 0, 1, 8, 4'b1100};
        vecs[12] = '{0, 4'hF, 4'hF, 1, 1, 0, 0, 7, 4'b1100};
        vecs[13] = '{0, 4'hF, 4'hF, 1, 0, 0, 1, 8, 4'b1101};
        exp_lock = '{1, 1, 1, 2, 0};

        w_Rst = 1'b1; req_Valid = '0; req_Last = '0; req_Data = '0;
        rd_bin = 0; wsync_Rptr = '0;
        model_reset();
        @(posedge w_Clk);
        #1;

        // Reset/idle, round-robin fill, full stall and single-slot drain.
        for (int i = 0; i < 14; i++) begin
            w_Rst = vecs[i].rst; req_Valid = vecs[i].valid; req_Last = vecs[i].last;
            req_Data = NR*DW'($urandom); rd_bin = vecs[i].rd;
            do_cycle();
            check("vec_en", cap_en, int'(vecs[i].en));
            check("vec_full", cap_full, int'(vecs[i].full));
            check("vec_level", cap_level, vecs[i].level);
            check("vec_ptr", cap_ptr, int'(vecs[i].ptr));
            if (vecs[i].en) check("vec_gid", cap_gid, vecs[i].gid);
        end

        // Packet lock: req1 owns the port for 3 beats while req0/req2 wait.
        reset_dut(2);
        got.delete();
        req_Valid = 4'b0001; req_Last = 4'b0001; rd_bin = m_wr;
        do_cycle();
        for (int i = 0; i < 5; i++) begin
            req_Valid = (i < 3) ? 4'b0111 : 4'b0101;
            req_Last  = (i == 2) ? 4'b0111 : 4'b0101;
            req_Data  = NR*DW'($urandom);
            rd_bin    = m_wr;
            do_cycle();
            if (cap_en != 0) got.push_back(cap_gid);
        end
        check("lock_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) check("lock_order", got[i], exp_lock[i]);

        // Lock held across a full stall: beats 3-4 of req0 precede req3.
        reset_dut(2);
        got.delete();
        req_Valid = 4'b0010; req_Last = 4'b0010;
        for (int i = 0; i < 6; i++) do_cycle();
        cnt = 0;
        for (int i = 0; i < 11; i++) begin
            req_Valid = (i < 2) ? 4'b0001 : 4'b1001;
            req_Last  = {1'b1, 2'b00, (cnt == 3)};
            req_Data  = NR*DW'($urandom);
            rd_bin    = (i >= 5) ? 2 : 0;
            do_cycle();
            if (cap_en != 0) got.push_back(cap_gid);
            if (i >= 2 && i <= 5) check("stall_no_en", cap_en, 0);
            if (m_acc != 0 && m_g == 0) cnt++;
        end
        check("full_lock_count", got.size(), 4);
        foreach (got[i]) check("full_lock_owner", got[i], 0);

        // Pointer wrap with the read pointer trailing two cycles behind.
        reset_dut(1);
        cnt = 0;
        req_Valid = 4'b1111; req_Last = 4'b1111;
        for (int i = 0; i < 80 && cnt < 20; i++) begin
            req_Data = NR*DW'($urandom);
            rd_bin   = lagged_wr();
            do_cycle();
            if (m_acc != 0) cnt++;
            if (cap_level > DEPTH) check("level_bound", cap_level, DEPTH);
        end
        check("wrap_writes", cnt, 20);

        // Randomized traffic, including occasional mid-packet resets.
        for (int i = 0; i < 400; i++) begin
            int d;
            w_Rst     = ($urandom_range(0, 99) == 0);
            req_Valid = NR'($urandom);
            req_Last  = NR'($urandom) | NR'($urandom);
            req_Data  = NR*DW'($urandom);
            d = (lagged_wr() - rd_bin + PMOD) % PMOD;
            if (d > 0 && d <= DEPTH && $urandom_range(0, 2) != 0) rd_bin = (rd_bin + 1) % PMOD;
            if (w_Rst) begin
                rd_bin = 0;
                hist.delete();
            end
            do_cycle();
            if (w_Rst) hist.delete();
        end
        w_Rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
